// File: rtl/wrr_pkt_arbiter.sv
// wrr_pkt_arbiter: weighted round-robin arbiter that grants whole packets.
// Each turn allows up to i_weight packets. A turn ends early when the requester drops its request between packets.
module wrr_pkt_arbiter #(
    parameter  int N_REQ    = 16,
    parameter  int WEIGHT_W = 4,
    localparam int IW       = $clog2(N_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_last,
    input  logic [N_REQ*WEIGHT_W-1:0] i_weight,
    input  logic                      i_ack,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_grant_vld,
    output logic [IW-1:0]             o_grant_idx
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d, idx_q, idx_d, pick_idx;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                in_pkt_q, in_pkt_d, pick_vld, beat, rel;
    logic [IW:0]         cand;
    logic [WEIGHT_W-1:0] wt [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_wt
        assign wt[k] = i_weight[k*WEIGHT_W +: WEIGHT_W];
    end

    // Scan downward so the last hit is the nearest requester at or after ptr.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            cand = (cand >= (IW+1)'(N_REQ)) ? cand - (IW+1)'(N_REQ) : cand;
            if (i_req[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    assign beat = (state_q == GRANT) && i_ack && i_req[idx_q];
    assign rel  = (state_q == GRANT) &&
                  ((beat && i_last[idx_q] && credit_q == WEIGHT_W'(1)) ||
                   (!in_pkt_q && !beat && !i_req[idx_q]));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        credit_d = credit_q;
        in_pkt_d = in_pkt_q;
        grant_d  = grant_q;
        if (state_q == IDLE) begin
            if (pick_vld) begin
                state_d  = GRANT;
                idx_d    = pick_idx;
                grant_d  = N_REQ'(1) << pick_idx;
                credit_d = (wt[pick_idx] == '0) ? WEIGHT_W'(1) : wt[pick_idx];
            end
        end else if (rel) begin
            state_d  = IDLE;
            idx_d    = '0;
            grant_d  = '0;
            credit_d = '0;
            in_pkt_d = 1'b0;
            ptr_d    = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
        end else if (beat) begin
            in_pkt_d = !i_last[idx_q];
            credit_d = i_last[idx_q] ? credit_q - WEIGHT_W'(1) : credit_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            credit_q <= '0;
            in_pkt_q <= 1'b0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            credit_q <= credit_d;
            in_pkt_q <= in_pkt_d;
            grant_q  <= grant_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_grant_vld = |grant_q;
    assign o_grant_idx = idx_q;
endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// tb_wrr_pkt_arbiter: directed checks of grant order, packet lock, weights and reset for a 4-port arbiter.
module tb_wrr_pkt_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [3:0]  i_req = '0;
    logic [3:0]  i_last = '0;
    logic [15:0] i_weight = 16'h1111;
    logic        i_ack = 1'b0;
    logic [3:0]  o_grant;
    logic        o_grant_vld;
    logic [1:0]  o_grant_idx;
    int n_chk = 0;
    int n_pass = 0;
    int n_cyc = 0;

    always #5 i_clk = ~i_clk;

    wrr_pkt_arbiter #(.N_REQ(4), .WEIGHT_W(4)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_req(i_req),
        .i_last(i_last),
        .i_weight(i_weight),
        .i_ack(i_ack),
        .o_grant(o_grant),
        .o_grant_vld(o_grant_vld),
        .o_grant_idx(o_grant_idx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] g);
        logic [1:0] ix;
        ix = '0;
        for (int i = 0; i < 4; i++) if (g[i]) ix = 2'(i);
        chk({tag, "_grant"}, 32'(o_grant), 32'(g));
        chk({tag, "_vld"}, 32'(o_grant_vld), 32'(|g));
        chk({tag, "_idx"}, 32'(o_grant_idx), 32'(ix));
    endtask

    task automatic step(input logic [3:0] g);
        @(posedge i_clk);
        #1;
        n_cyc++;
        expect_grant($sformatf("c%0d", n_cyc), g);
    endtask

    initial begin
        i_ack  = 1'b1;
        i_last = 4'hf;
        #1;
        expect_grant("rst", 4'b0000);
        step(4'b0000);
        i_rst_n = 1'b1;
        i_req   = 4'b1010;
        step(4'b0010);
        step(4'b0000);
        step(4'b1000);
        step(4'b0000);
        step(4'b0010);
        i_req = 4'b0000;
        step(4'b0000);
        i_weight = 16'h1113;
        i_req    = 4'b0001;
        repeat (2) begin
            step(4'b0001);
            step(4'b0001);
            step(4'b0001);
            step(4'b0000);
        end
        i_req    = 4'b0100;
        i_weight = 16'h2111;
        i_last   = 4'h0;
        step(4'b0100);
        step(4'b0100);
        i_ack = 1'b0;
        step(4'b0100);
        i_ack = 1'b1;
        step(4'b0100);
        i_req = 4'b0000;
        step(4'b0100);
        i_ack = 1'b0;
        step(4'b0100);
        i_req = 4'b0100;
        i_ack = 1'b1;
        step(4'b0100);
        i_ack = 1'b0;
        step(4'b0100);
        i_ack  = 1'b1;
        i_last = 4'hf;
        step(4'b0000);
        i_req = 4'b1001;
        step(4'b1000);
        i_weight = 16'h1111;
        step(4'b1000);
        i_req = 4'b0001;
        step(4'b0000);
        step(4'b0001);
        i_req = 4'b0000;
        step(4'b0000);
        i_weight = 16'h1101;
        i_req    = 4'b0010;
        step(4'b0010);
        step(4'b0000);
        step(4'b0010);
        i_req = 4'b0000;
        step(4'b0000);
        i_req  = 4'b0010;
        i_last = 4'h0;
        step(4'b0010);
        step(4'b0010);
        i_req   = 4'b0110;
        i_rst_n = 1'b0;
        #1;
        expect_grant("midrst", 4'b0000);
        step(4'b0000);
        i_rst_n = 1'b1;
        step(4'b0010);
        i_last = 4'hf;
        step(4'b0000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
